pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have a clk input of width 1: the single clock, with all state updating on its rising edge.
REQ-002 The block SHALL have a rst input of width 1: synchronous, active-high reset.
REQ-003 The block SHALL have a pc output of width 8: registered fetch address driven to the instruction ROM.
REQ-004 The block SHALL have a rom_data input of width 16: combinational ROM word for the current pc.
REQ-005 The block SHALL have an ir output of width 16: registered instruction.
REQ-006 The block SHALL have an ir_pc output of width 8: address from which ir was fetched.
REQ-007 The block SHALL have an ir_valid output of width 1: ir holds a live instruction.
REQ-008 The block SHALL have a stall input of width 1: hold pc, ir, ir_pc and ir_valid.
REQ-009 The block SHALL have jump_req (input, width 1) and jump_target (input, width 8): absolute redirect.
REQ-010 The block SHALL have branch_req (input, width 1) and branch_offset (input, width 8, two's complement): relative redirect.
REQ-011 The block SHALL have call_req, ret_req and halt_req inputs (width 1 each), and a resume input (width 1).
REQ-012 The block SHALL have a halted output (width 1) and a ras_err output (width 1, one-cycle pulse).

Function
REQ-013 The state machine SHALL have exactly three states: BOOT, FETCH, HALT.
REQ-014 BOOT SHALL last exactly one cycle after reset release, with pc=0 and ir_valid=0, then go to FETCH.
REQ-015 In FETCH with no event: ir<=rom_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1; pc wraps 255->0.
REQ-016 Event priority per cycle SHALL be: halt_req > jump_req > branch_req > call_req > ret_req > stall > sequential.
REQ-017 Jump: pc<=jump_target; ir<=16'h0000; ir_valid<=0 for exactly one cycle (single bubble).
REQ-018 Branch: pc<=(ir_pc+branch_offset) mod 256; bubble as in REQ-017; branch_req while ir_valid=0 SHALL be ignored.
REQ-019 Redirects (jump, branch, call, ret) SHALL override stall.
REQ-020 Stall with no redirect SHALL hold all outputs unchanged, including ir_valid.
REQ-021 halt_req in FETCH: go to HALT, ir_valid<=0, pc frozen, halted=1 from the next cycle.
REQ-022 In HALT, all requests except resume SHALL be ignored; resume returns to FETCH, fetching from the frozen pc.
REQ-023 halt_req and resume both asserted in HALT: resume wins.
REQ-024 Requests in BOOT SHALL be ignored.

Reset
REQ-025 On rst=1 at a clock edge: state=BOOT, pc=0, ir=0, ir_pc=0, ir_valid=0, halted=0, ras_err=0, return stack empty.
REQ-026 rst SHALL override every other input, including mid-stall, mid-halt and mid-redirect.

Configuration
REQ-027 With macro FETCH_RAS_EN defined, a 4-entry return-address stack SHALL be built.
REQ-028 Call (FETCH_RAS_EN defined): push ir_pc+1 (mod 256), pc<=jump_target, one bubble.
REQ-029 Call when the stack is full (FETCH_RAS_EN defined): the oldest entry is overwritten, with no error.
REQ-030 Return (FETCH_RAS_EN defined): pop into pc, one bubble.
REQ-031 Return on an empty stack (FETCH_RAS_EN defined): pc<=0, ras_err pulses for 1 cycle, bubble.
REQ-032 Without FETCH_RAS_EN: call_req SHALL behave exactly as jump_req, ret_req SHALL be ignored, ras_err SHALL be tied to 0, and no stack storage SHALL exist.

Verification
REQ-033 Reset then free-run with ROM[n]=n: pc=0 during BOOT; ir_valid first high with ir=0, ir_pc=0; pc=255 followed by pc=0.
REQ-034 Jump: ir_pc=5 and jump_req with target 8'h40 -> one cycle ir_valid=0, ir=0; next ir_pc=8'h40.
REQ-035 Branch: ir_pc=3 and offset 8'hFE -> next live ir_pc=1; same request with ir_valid=0 -> ignored.
REQ-036 Stall: stall high 3 cycles at pc=7 -> outputs frozen; stall and jump_req to 8'h20 in the same cycle -> jump taken.
REQ-037 Halt: halt_req at pc=9 -> halted=1, pc stays 9; resume -> ir_pc=9 next live instruction; rst asserted mid-halt -> BOOT state.
REQ-038 With FETCH_RAS_EN defined: 5 nested calls then 5 returns -> 4 correct return addresses; 5th return gives pc=0 and a single-cycle ras_err pulse.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter / instruction-fetch sequencer.
// Fetches one 16-bit instruction per cycle from a combinational ROM.
// Supports stall, absolute jump, relative branch, call/return, halt and resume.
// Optional feature: define FETCH_RAS_EN to build a 4-entry return-address stack.
// Without FETCH_RAS_EN, call acts as jump, return is ignored and ras_err is tied low.
module pc_sequencer (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  pc,
    input  logic [15:0] rom_data,
    output logic [15:0] ir,
    output logic [7:0]  ir_pc,
    output logic        ir_valid,
    input  logic        stall,
    input  logic        jump_req,
    input  logic [7:0]  jump_target,
    input  logic        branch_req,
    input  logic [7:0]  branch_offset,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic        halt_req,
    input  logic        resume,
    output logic        halted,
    output logic        ras_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        halted_q, halted_d;
    logic        redirect;
    logic [7:0]  redirect_target;

`ifdef FETCH_RAS_EN
    // Circular stack: a push onto a full stack naturally replaces the oldest entry.
    logic [7:0]  ras_q [4];
    logic [7:0]  ras_d [4];
    logic [1:0]  ras_top_q, ras_top_d;
    logic [2:0]  ras_cnt_q, ras_cnt_d;
    logic        ras_err_q, ras_err_d;
    logic [1:0]  pop_idx;

    assign pop_idx = ras_top_q - 2'd1;
    assign ras_err = ras_err_q;
`else
    logic unused_ret;

    assign unused_ret = ret_req;
    assign ras_err    = 1'b0;
`endif

    // Next-state logic: one event per cycle, chosen by fixed priority.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ir_d            = ir_q;
        ir_pc_d         = ir_pc_q;
        ir_valid_d      = ir_valid_q;
        halted_d        = halted_q;
        redirect        = 1'b0;
        redirect_target = 8'h00;
`ifdef FETCH_RAS_EN
        ras_d           = ras_q;
        ras_top_d       = ras_top_q;
        ras_cnt_d       = ras_cnt_q;
        ras_err_d       = 1'b0;
`endif
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (halt_req) begin
                    state_d    = HALT;
                    ir_valid_d = 1'b0;
                    halted_d   = 1'b1;
                end else if (jump_req) begin
                    redirect        = 1'b1;
                    redirect_target = jump_target;
                end else if (branch_req && ir_valid_q) begin
                    redirect        = 1'b1;
                    redirect_target = ir_pc_q + branch_offset;
                end else if (call_req) begin
                    redirect        = 1'b1;
                    redirect_target = jump_target;
`ifdef FETCH_RAS_EN
                    ras_d[ras_top_q] = ir_pc_q + 8'd1;
                    ras_top_d        = ras_top_q + 2'd1;
                    ras_cnt_d        = (ras_cnt_q == 3'd4) ? 3'd4 : ras_cnt_q + 3'd1;
`endif
                end
`ifdef FETCH_RAS_EN
                else if (ret_req) begin
                    redirect = 1'b1;
                    if (ras_cnt_q == 3'd0) begin
                        redirect_target = 8'h00;
                        ras_err_d       = 1'b1;
                    end else begin
                        redirect_target = ras_q[pop_idx];
                        ras_top_d       = pop_idx;
                        ras_cnt_d       = ras_cnt_q - 3'd1;
                    end
                end
`endif
                else if (!stall) begin
                    ir_d       = rom_data;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + 8'd1;
                end
            end
            HALT: begin
                if (resume) begin
                    state_d  = FETCH;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (redirect) begin
            pc_d       = redirect_target;
            ir_d       = 16'h0000;
            ir_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset to the BOOT state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= 8'h00;
            ir_q       <= 16'h0000;
            ir_pc_q    <= 8'h00;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

`ifdef FETCH_RAS_EN
    // Return-address stack registers; reset leaves the stack empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_q     <= '{default: 8'h00};
            ras_top_q <= 2'd0;
            ras_cnt_q <= 3'd0;
            ras_err_q <= 1'b0;
        end else begin
            ras_q     <= ras_d;
            ras_top_q <= ras_top_d;
            ras_cnt_q <= ras_cnt_d;
            ras_err_q <= ras_err_d;
        end
    end
`endif

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scenario tasks plus randomized run against a behavioural model.
// Follows FETCH_RAS_EN the same way the design does.
module tb_pc_sequencer;

`ifdef FETCH_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam int MODE_BOOT   = 0;
    localparam int MODE_RUN    = 1;
    localparam int MODE_HALTED = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pc;
    logic [15:0] rom_data;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        stall, jump_req, branch_req, call_req, ret_req, halt_req, resume;
    logic [7:0]  jump_target, branch_offset;
    logic        halted, ras_err;
    logic        rom_scramble;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int          m_mode;
    logic [7:0]  m_pc, m_ir_pc;
    logic [15:0] m_ir;
    logic        m_valid, m_halted, m_err;
    logic [7:0]  m_stack [$];

    pc_sequencer dut (
        .clk(clk), .rst(rst), .pc(pc), .rom_data(rom_data), .ir(ir), .ir_pc(ir_pc),
        .ir_valid(ir_valid), .stall(stall), .jump_req(jump_req), .jump_target(jump_target),
        .branch_req(branch_req), .branch_offset(branch_offset), .call_req(call_req),
        .ret_req(ret_req), .halt_req(halt_req), .resume(resume), .halted(halted),
        .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_of(input logic [7:0] a);
        return rom_scramble ? {~a, a} : {8'h00, a};
    endfunction

    assign rom_data = rom_of(pc);

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        int   sum;
        bit   redir;
        logic [7:0] tgt;
        redir = 0;
        tgt   = 8'h00;
        m_err = 1'b0;
        if (rst) begin
            m_mode = MODE_BOOT; m_pc = 0; m_ir = 0; m_ir_pc = 0;
            m_valid = 0; m_halted = 0; m_stack.delete();
        end else if (m_mode == MODE_BOOT) begin
            m_mode = MODE_RUN;
        end else if (m_mode == MODE_HALTED) begin
            if (resume) begin
                m_mode = MODE_RUN;
                m_halted = 1'b0;
            end
        end else begin
            if (halt_req) begin
                m_mode = MODE_HALTED; m_valid = 1'b0; m_halted = 1'b1;
            end else if (jump_req) begin
                redir = 1; tgt = jump_target;
            end else if (branch_req && m_valid) begin
                sum = int'(m_ir_pc) + int'($signed(branch_offset)) + 256;
                redir = 1; tgt = 8'(sum % 256);
            end else if (call_req) begin
                redir = 1; tgt = jump_target;
                if (RAS_EN) begin
                    m_stack.push_back(8'((int'(m_ir_pc) + 1) % 256));
                    if (m_stack.size() > 4) void'(m_stack.pop_front());
                end
            end else if (ret_req && RAS_EN) begin
                redir = 1;
                if (m_stack.size() == 0) begin
                    tgt = 8'h00; m_err = 1'b1;
                end else begin
                    tgt = m_stack.pop_back();
                end
            end else if (!stall) begin
                m_ir = rom_of(m_pc); m_ir_pc = m_pc; m_valid = 1'b1;
                m_pc = 8'((int'(m_pc) + 1) % 256);
            end
            if (redir) begin
                m_pc = tgt; m_ir = 16'h0000; m_valid = 1'b0;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; jump_req = 0; branch_req = 0; call_req = 0; ret_req = 0;
        halt_req = 0; resume = 0; jump_target = 8'h00; branch_offset = 8'h00;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_to_pc(input logic [7:0] t, output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (pc === t) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic run_to_ir_pc(input logic [7:0] t, output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (ir_valid === 1'b1 && ir_pc === t) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1; jump_req = 1; jump_target = 8'h5A; halt_req = 1; call_req = 1; ret_req = 1;
        step();
        step();
        checks++; if (pc !== 8'h00) begin errors++; $display("[TB] FAIL reset_pc got %h want 00", pc); end
        checks++; if (ir !== 16'h0000) begin errors++; $display("[TB] FAIL reset_ir got %h want 0000", ir); end
        checks++; if (ir_pc !== 8'h00) begin errors++; $display("[TB] FAIL reset_ir_pc got %h want 00", ir_pc); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ir_valid got %b want 0", ir_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %b want 0", halted); end
        checks++; if (ras_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ras_err got %b want 0", ras_err); end
        clear_inputs();
    endtask

    task automatic test_free_run();
        logic [7:0] prev;
        bit wrap_seen;
        rom_scramble = 1'b0;
        do_reset();
        checks++; if (pc !== 8'h00 || ir_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL boot_state pc=%h ir_valid=%b want 00/0", pc, ir_valid);
        end
        jump_req = 1; jump_target = 8'h77;
        step();
        clear_inputs();
        checks++; if (pc !== 8'h00 || ir_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL boot_ignores_req pc=%h ir_valid=%b want 00/0", pc, ir_valid);
        end
        step();
        checks++; if (ir_valid !== 1'b1 || ir !== 16'h0000 || ir_pc !== 8'h00 || pc !== 8'h01) begin
            errors++; $display("[TB] FAIL first_fetch valid=%b ir=%h ir_pc=%h pc=%h want 1/0000/00/01", ir_valid, ir, ir_pc, pc);
        end
        wrap_seen = 0;
        for (int i = 0; i < 300; i++) begin
            prev = pc;
            step();
            if (prev == 8'hFF && pc === 8'h00) wrap_seen = 1;
            checks++;
            if ({pc, ir, ir_pc, ir_valid, halted, ras_err} !== {m_pc, m_ir, m_ir_pc, m_valid, m_halted, m_err}) begin
                errors++;
                $display("[TB] FAIL free_run cyc %0d got pc=%h ir=%h ir_pc=%h v=%b want pc=%h ir=%h ir_pc=%h v=%b",
                         i, pc, ir, ir_pc, ir_valid, m_pc, m_ir, m_ir_pc, m_valid);
            end
        end
        checks++; if (!wrap_seen) begin errors++; $display("[TB] FAIL pc_wrap got no 255->0 want wrap"); end
        rom_scramble = 1'b1;
    endtask

    task automatic test_jump();
        bit ok;
        do_reset();
        run_to_ir_pc(8'h05, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL jump_reach ir_pc=%h want 05", ir_pc); end
        jump_req = 1; jump_target = 8'h40;
        step();
        clear_inputs();
        checks++; if (ir_valid !== 1'b0 || ir !== 16'h0000 || pc !== 8'h40) begin
            errors++; $display("[TB] FAIL jump_bubble valid=%b ir=%h pc=%h want 0/0000/40", ir_valid, ir, pc);
        end
        step();
        checks++; if (ir_valid !== 1'b1 || ir_pc !== 8'h40 || ir !== 16'hBF40) begin
            errors++; $display("[TB] FAIL jump_target valid=%b ir_pc=%h ir=%h want 1/40/bf40", ir_valid, ir_pc, ir);
        end
    endtask

    task automatic test_branch();
        bit ok;
        do_reset();
        run_to_ir_pc(8'h03, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL branch_reach ir_pc=%h want 03", ir_pc); end
        branch_req = 1; branch_offset = 8'hFE;
        step();
        clear_inputs();
        checks++; if (ir_valid !== 1'b0 || pc !== 8'h01) begin
            errors++; $display("[TB] FAIL branch_bubble valid=%b pc=%h want 0/01", ir_valid, pc);
        end
        step();
        checks++; if (ir_valid !== 1'b1 || ir_pc !== 8'h01) begin
            errors++; $display("[TB] FAIL branch_target valid=%b ir_pc=%h want 1/01", ir_valid, ir_pc);
        end
        jump_req = 1; jump_target = 8'h30;
        step();
        clear_inputs();
        branch_req = 1; branch_offset = 8'hFE;
        step();
        clear_inputs();
        checks++; if (ir_valid !== 1'b1 || ir_pc !== 8'h30 || pc !== 8'h31) begin
            errors++; $display("[TB] FAIL branch_ignored valid=%b ir_pc=%h pc=%h want 1/30/31", ir_valid, ir_pc, pc);
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [32:0] snap;
        do_reset();
        run_to_pc(8'h07, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL stall_reach pc=%h want 07", pc); end
        snap = {pc, ir, ir_pc, ir_valid};
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({pc, ir, ir_pc, ir_valid} !== snap) begin
                errors++; $display("[TB] FAIL stall_hold cyc %0d got %h want %h", i, {pc, ir, ir_pc, ir_valid}, snap);
            end
        end
        jump_req = 1; jump_target = 8'h20;
        step();
        clear_inputs();
        checks++; if (pc !== 8'h20 || ir_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_jump pc=%h valid=%b want 20/0", pc, ir_valid);
        end
        step();
        checks++; if (ir_pc !== 8'h20 || ir_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_jump_fetch ir_pc=%h valid=%b want 20/1", ir_pc, ir_valid);
        end
    endtask

    task automatic test_halt();
        bit ok;
        do_reset();
        run_to_pc(8'h09, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL halt_reach pc=%h want 09", pc); end
        halt_req = 1;
        step();
        clear_inputs();
        checks++; if (halted !== 1'b1 || pc !== 8'h09 || ir_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL halt_enter halted=%b pc=%h valid=%b want 1/09/0", halted, pc, ir_valid);
        end
        jump_req = 1; branch_req = 1; call_req = 1; ret_req = 1; halt_req = 1;
        jump_target = 8'hAA; branch_offset = 8'h10;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (halted !== 1'b1 || pc !== 8'h09) begin
                errors++; $display("[TB] FAIL halt_ignore cyc %0d halted=%b pc=%h want 1/09", i, halted, pc);
            end
        end
        clear_inputs();
        halt_req = 1; resume = 1;
        step();
        clear_inputs();
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL resume_wins halted=%b want 0", halted); end
        step();
        checks++; if (ir_valid !== 1'b1 || ir_pc !== 8'h09) begin
            errors++; $display("[TB] FAIL resume_fetch valid=%b ir_pc=%h want 1/09", ir_valid, ir_pc);
        end
        halt_req = 1;
        step();
        clear_inputs();
        rst = 1; stall = 1;
        step();
        rst = 0; stall = 0;
        checks++; if (halted !== 1'b0 || pc !== 8'h00 || ir_valid !== 1'b0 || ir !== 16'h0000) begin
            errors++; $display("[TB] FAIL halt_reset halted=%b pc=%h valid=%b ir=%h want 0/00/0/0000", halted, pc, ir_valid, ir);
        end
        jump_req = 1; jump_target = 8'h33;
        step();
        clear_inputs();
        step();
        checks++; if (ir_valid !== 1'b1 || ir_pc !== 8'h00 || ir !== 16'hFF00) begin
            errors++; $display("[TB] FAIL halt_reboot valid=%b ir_pc=%h ir=%h want 1/00/ff00", ir_valid, ir_pc, ir);
        end
    endtask

    task automatic test_call_return();
        bit ok;
        do_reset();
        run_to_ir_pc(8'h10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL call_reach ir_pc=%h want 10", ir_pc); end
`ifdef FETCH_RAS_EN
        begin
            logic [7:0] want [5];
            want = '{8'h71, 8'h61, 8'h51, 8'h41, 8'h00};
            for (int k = 0; k < 5; k++) begin
                call_req = 1; jump_target = 8'(8'h40 + k * 16);
                step();
                clear_inputs();
                step();
            end
            for (int r = 0; r < 5; r++) begin
                ret_req = 1;
                step();
                clear_inputs();
                checks++;
                if (pc !== want[r] || ir_valid !== 1'b0 || ras_err !== (r == 4)) begin
                    errors++; $display("[TB] FAIL ret_%0d pc=%h valid=%b ras_err=%b want %h/0/%0d", r, pc, ir_valid, ras_err, want[r], r == 4);
                end
                step();
            end
            checks++; if (ras_err !== 1'b0) begin errors++; $display("[TB] FAIL ras_err_pulse got %b want 0", ras_err); end
        end
`else
        call_req = 1; jump_target = 8'h40;
        step();
        clear_inputs();
        checks++; if (pc !== 8'h40 || ir_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL call_as_jump pc=%h valid=%b want 40/0", pc, ir_valid);
        end
        step();
        ret_req = 1;
        step();
        clear_inputs();
        checks++; if (pc !== 8'h42 || ir_valid !== 1'b1 || ir_pc !== 8'h41 || ras_err !== 1'b0) begin
            errors++; $display("[TB] FAIL ret_ignored pc=%h valid=%b ir_pc=%h ras_err=%b want 42/1/41/0", pc, ir_valid, ir_pc, ras_err);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(63) == 0);
            halt_req      = ($urandom_range(15) == 0);
            resume        = ($urandom_range(3) == 0);
            jump_req      = ($urandom_range(9) == 0);
            branch_req    = ($urandom_range(7) == 0);
            call_req      = ($urandom_range(7) == 0);
            ret_req       = ($urandom_range(6) == 0);
            stall         = ($urandom_range(4) == 0);
            jump_target   = 8'($urandom);
            branch_offset = 8'($urandom);
            step();
            checks++;
            if ({pc, ir, ir_pc, ir_valid, halted, ras_err} !== {m_pc, m_ir, m_ir_pc, m_valid, m_halted, m_err}) begin
                errors++;
                $display("[TB] FAIL random cyc %0d got pc=%h ir=%h ir_pc=%h v=%b h=%b e=%b want pc=%h ir=%h ir_pc=%h v=%b h=%b e=%b",
                         i, pc, ir, ir_pc, ir_valid, halted, ras_err, m_pc, m_ir, m_ir_pc, m_valid, m_halted, m_err);
            end
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        rom_scramble = 1'b1;
        rst = 1'b1;
        clear_inputs();
        m_mode = MODE_BOOT; m_pc = 0; m_ir = 0; m_ir_pc = 0;
        m_valid = 0; m_halted = 0; m_err = 0;
        test_reset();
        test_free_run();
        test_jump();
        test_branch();
        test_stall();
        test_halt();
        test_call_return();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
